// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
//   Shared types and helpers for the handshaked priority encoder.
//   - enc_state_t   : two-state issue FSM (IDLE: nothing issued, HOLD: index on output)
//   - MAX_N         : widest request vector the index helper can decode
//   - onehot_to_idx : encodes a one-hot vector (zero-extended to MAX_N) into its index
// ---------------------------------------------------------------------------
package enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    localparam int unsigned MAX_N = 64;

    // OR-reduction of the set bit positions. For a true one-hot input this is
    // exactly the index; no priority chain is needed because only one bit is set.
    function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
//   Combinational lowest-set-index finder.
//   Ports:
//     vec_i     in  N  candidate vector
//     idx_o     out W  index of the lowest set bit (0 when vec_i is zero)
//     onehot_o  out N  one-hot of that bit (all zero when vec_i is zero)
//     found_o   out 1  vec_i has at least one bit set
//   N must not exceed enc_pkg::MAX_N.
// ---------------------------------------------------------------------------
module prio_pick
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o,
    output logic         found_o
);

    logic [N-1:0] lowest;

    // Two's-complement trick: v & -v isolates the lowest set bit within N bits.
    assign lowest   = vec_i & (~vec_i + N'(1));
    assign onehot_o = lowest;
    assign found_o  = |vec_i;
    assign idx_o    = W'(onehot_to_idx(MAX_N'(lowest)));

endmodule

// File: rtl/prio_encoder_hs.sv
// ---------------------------------------------------------------------------
// prio_encoder_hs
//   N:log2(N) priority encoder with a sticky pending-request register and a
//   registered valid/ready output. Requests are latched and issued one index
//   per handshake, lowest-index-first or round-robin.
//   Ports:
//     clk         in   1  rising-edge clock
//     rst         in   1  synchronous active-high reset
//     req_in      in   N  request vector
//     req_load    in   1  OR req_in into pending at this edge
//     mode_rr     in   1  0: fixed priority, 1: round-robin
//     out_ready   in   1  consumer accepts the issued index
//     out_valid   out  1  out_idx/out_onehot hold an issued request
//     out_idx     out  W  issued index (keeps last value once idle)
//     out_onehot  out  N  one-hot of out_idx, zero when idle
//     pending     out  N  latched, not-yet-issued requests
//     busy        out  1  out_valid | (|pending)
// ---------------------------------------------------------------------------
module prio_encoder_hs
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         req_load,
    input  logic         mode_rr,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pending,
    output logic         busy
);

    enc_state_t   state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic [N-1:0] out_onehot_q, out_onehot_d;

    logic [N-1:0] rr_mask;
    logic [W-1:0] m_idx, u_idx, sel_idx;
    logic [N-1:0] m_oh, u_oh, sel_oh;
    logic         m_found, u_found;
    logic         issue;

    // Bits strictly above rr_ptr. Built per bit so no arithmetic wider than N
    // is needed and rr_ptr = N-1 simply yields an empty mask (forcing a wrap).
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rr_mask[i] = (i > int'(rr_ptr_q));
        end
    end

    prio_pick #(.N(N)) u_pick_masked (
        .vec_i    (pending_q & rr_mask),
        .idx_o    (m_idx),
        .onehot_o (m_oh),
        .found_o  (m_found)
    );

    prio_pick #(.N(N)) u_pick_raw (
        .vec_i    (pending_q),
        .idx_o    (u_idx),
        .onehot_o (u_oh),
        .found_o  (u_found)
    );

    // Round-robin falls back to the unmasked pick when nothing lies above
    // rr_ptr; fixed mode always uses the unmasked pick.
    assign sel_idx = (mode_rr && m_found) ? m_idx : u_idx;
    assign sel_oh  = (mode_rr && m_found) ? m_oh  : u_oh;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (u_found) begin
                    issue   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (u_found) begin
                        issue = 1'b1;          // back-to-back, no bubble
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: output / datapath next values ----------------
    always_comb begin
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        rr_ptr_d     = rr_ptr_q;
        if (issue) begin
            out_idx_d    = sel_idx;
            out_onehot_d = sel_oh;
            rr_ptr_d     = sel_idx;
        end else if (state_q == HOLD && state_d == IDLE) begin
            out_onehot_d = '0;                 // out_idx deliberately keeps its value
        end
        // Clear before set: a bit re-requested in its own selection cycle stays pending.
        pending_d = (pending_q & ~(issue ? sel_oh : '0)) | (req_load ? req_in : '0);
    end

    // NOTE: the whole datapath is reset, including pending; reset also beats a
    // same-cycle req_load and drops any in-flight index without a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            rr_ptr_q     <= W'(N - 1);         // first RR pick equals the fixed pick
            out_idx_q    <= '0;
            out_onehot_q <= '0;
        end else begin
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign pending    = pending_q;
    assign busy       = out_valid | (|pending_q);

endmodule
